rv32_regs_ctrl: RTL and testbench

Port controller wrapped around the RV32 register file. Sequences a post-reset clear of x1–x31 and adds write-to-read bypass plus x0 masking on both read ports. Also shares the file's single write port and rs1 read port between the pipeline and a debug access port. Sits between decode/writeback and the register file, which it drives directly.

---
 rtl/rv32_regs_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rv32_regs_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_regs_ctrl.sv
// rv32_regs_ctrl: port controller in front of the RV32 register file.
// Post-reset clear, x0 masking, write-to-read bypass, debug access sharing.
module rv32_regs_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pipe_stall_in,
    input  logic [4:0]  pipe_rs1_in,
    input  logic [4:0]  pipe_rs2_in,
    input  logic [4:0]  pipe_rd_in,
    input  logic        pipe_rd_write_in,
    input  logic [31:0] pipe_rd_value_in,
    output logic [31:0] pipe_rs1_value_out,
    output logic [31:0] pipe_rs2_value_out,
    output logic        pipe_stall_out,
    output logic        clear_done_out,
    input  logic        dbg_req_in,
    input  logic        dbg_write_in,
    input  logic [4:0]  dbg_addr_in,
    input  logic [31:0] dbg_wdata_in,
    output logic        dbg_ack_out,
    output logic [31:0] dbg_rdata_out,
    output logic        regs_stall_out,
    output logic [4:0]  regs_rs1_out,
    output logic [4:0]  regs_rs2_out,
    output logic [4:0]  regs_rd_out,
    output logic        regs_rd_write_out,
    output logic [31:0] regs_rd_value_out,
    input  logic [31:0] regs_rs1_value_in,
    input  logic [31:0] regs_rs2_value_in
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_DRD_ADDR,
        S_DRD_RESTORE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;

    // Pipeline-issued read addresses, restored after a debug read
    logic [4:0]  r_rs1_q;
    logic [4:0]  r_rs2_q;

    // Port 1 can carry the debug address, so track what it really issued
    logic [4:0]  r_iss1;

    logic        r_bp1;
    logic        r_bp2;
    logic [31:0] r_bpd1;
    logic [31:0] r_bpd2;

    logic        w_pipe_wr;
    logic        w_dbg_wr_grant;
    logic        w_wr_nz;
    logic        w_hit1_new;
    logic        w_hit2_new;
    logic        w_hit1_old;
    logic        w_hit2_old;
    logic [31:0] w_eff1;
    logic [31:0] w_eff2;

    assign w_pipe_wr      = pipe_rd_write_in && (pipe_rd_in != 5'd0);
    assign w_dbg_wr_grant = (r_state == S_IDLE) && dbg_req_in
                            && dbg_write_in && !w_pipe_wr;

    assign w_wr_nz    = regs_rd_write_out && (regs_rd_out != 5'd0);
    assign w_hit1_new = w_wr_nz && (regs_rd_out == regs_rs1_out);
    assign w_hit2_new = w_wr_nz && (regs_rd_out == regs_rs2_out);
    assign w_hit1_old = w_wr_nz && (regs_rd_out == r_iss1);
    assign w_hit2_old = w_wr_nz && (regs_rd_out == r_rs2_q);

    assign w_eff1 = (r_iss1 == 5'd0) ? 32'd0 :
                    r_bp1 ? r_bpd1 : regs_rs1_value_in;
    assign w_eff2 = (r_rs2_q == 5'd0) ? 32'd0 :
                    r_bp2 ? r_bpd2 : regs_rs2_value_in;

    assign pipe_rs1_value_out = w_eff1;
    assign pipe_rs2_value_out = w_eff2;
    assign clear_done_out     = (r_state != S_CLEAR);

    // Next state, write-port arbitration and read-port muxing
    always_comb begin
        w_state_nxt       = r_state;
        pipe_stall_out    = 1'b1;
        dbg_ack_out       = 1'b0;
        dbg_rdata_out     = 32'd0;
        regs_stall_out    = 1'b1;
        regs_rs1_out      = r_rs1_q;
        regs_rs2_out      = r_rs2_q;
        regs_rd_write_out = w_pipe_wr;
        regs_rd_out       = pipe_rd_in;
        regs_rd_value_out = pipe_rd_value_in;
        unique case (r_state)
            S_CLEAR: begin
                regs_rd_write_out = 1'b1;
                regs_rd_out       = r_cnt;
                regs_rd_value_out = 32'd0;
                if (r_cnt == 5'd31) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                pipe_stall_out = 1'b0;
                regs_stall_out = pipe_stall_in;
                regs_rs1_out   = pipe_rs1_in;
                regs_rs2_out   = pipe_rs2_in;
                if (w_dbg_wr_grant) begin
                    regs_rd_write_out = (dbg_addr_in != 5'd0);
                    regs_rd_out       = dbg_addr_in;
                    regs_rd_value_out = dbg_wdata_in;
                    dbg_ack_out       = 1'b1;
                end else if (dbg_req_in && !dbg_write_in) begin
                    w_state_nxt = S_DRD_ADDR;
                end
            end
            S_DRD_ADDR: begin
                regs_stall_out = 1'b0;
                regs_rs1_out   = dbg_addr_in;
                w_state_nxt    = S_DRD_RESTORE;
            end
            S_DRD_RESTORE: begin
                regs_stall_out = 1'b0;
                dbg_ack_out    = 1'b1;
                dbg_rdata_out  = w_eff1;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    // State register and clear counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= 5'd1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Addresses of reads issued by the pipeline itself
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rs1_q <= 5'd0;
            r_rs2_q <= 5'd0;
        end else if (r_state == S_IDLE && !pipe_stall_in) begin
            r_rs1_q <= pipe_rs1_in;
            r_rs2_q <= pipe_rs2_in;
        end
    end

    // Port 1 bypass: capture on issue, refresh while held
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_iss1 <= 5'd0;
            r_bp1  <= 1'b0;
            r_bpd1 <= 32'd0;
        end else if (!regs_stall_out) begin
            r_iss1 <= regs_rs1_out;
            r_bp1  <= w_hit1_new;
            r_bpd1 <= regs_rd_value_out;
        end else if (w_hit1_old) begin
            r_bp1  <= 1'b1;
            r_bpd1 <= regs_rd_value_out;
        end
    end

    // Port 2 bypass: same policy, address is always r_rs2_q
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bp2  <= 1'b0;
            r_bpd2 <= 32'd0;
        end else if (!regs_stall_out) begin
            r_bp2  <= w_hit2_new;
            r_bpd2 <= regs_rd_value_out;
        end else if (w_hit2_old) begin
            r_bp2  <= 1'b1;
            r_bpd2 <= regs_rd_value_out;
        end
    end

endmodule

// File: tb/tb_rv32_regs_ctrl.sv
// tb_rv32_regs_ctrl: scoreboard bench with an architectural register model.
// Register file modelled with registered, read-before-write ports.
module tb_rv32_regs_ctrl;

    logic        clk;
    logic        reset_n;
    logic        pipe_stall_in;
    logic [4:0]  pipe_rs1_in;
    logic [4:0]  pipe_rs2_in;
    logic [4:0]  pipe_rd_in;
    logic        pipe_rd_write_in;
    logic [31:0] pipe_rd_value_in;
    logic [31:0] pipe_rs1_value_out;
    logic [31:0] pipe_rs2_value_out;
    logic        pipe_stall_out;
    logic        clear_done_out;
    logic        dbg_req_in;
    logic        dbg_write_in;
    logic [4:0]  dbg_addr_in;
    logic [31:0] dbg_wdata_in;
    logic        dbg_ack_out;
    logic [31:0] dbg_rdata_out;
    logic        regs_stall_out;
    logic [4:0]  regs_rs1_out;
    logic [4:0]  regs_rs2_out;
    logic [4:0]  regs_rd_out;
    logic        regs_rd_write_out;
    logic [31:0] regs_rd_value_out;
    logic [31:0] regs_rs1_value_in;
    logic [31:0] regs_rs2_value_in;

    rv32_regs_ctrl dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .pipe_stall_in      (pipe_stall_in),
        .pipe_rs1_in        (pipe_rs1_in),
        .pipe_rs2_in        (pipe_rs2_in),
        .pipe_rd_in         (pipe_rd_in),
        .pipe_rd_write_in   (pipe_rd_write_in),
        .pipe_rd_value_in   (pipe_rd_value_in),
        .pipe_rs1_value_out (pipe_rs1_value_out),
        .pipe_rs2_value_out (pipe_rs2_value_out),
        .pipe_stall_out     (pipe_stall_out),
        .clear_done_out     (clear_done_out),
        .dbg_req_in         (dbg_req_in),
        .dbg_write_in       (dbg_write_in),
        .dbg_addr_in        (dbg_addr_in),
        .dbg_wdata_in       (dbg_wdata_in),
        .dbg_ack_out        (dbg_ack_out),
        .dbg_rdata_out      (dbg_rdata_out),
        .regs_stall_out     (regs_stall_out),
        .regs_rs1_out       (regs_rs1_out),
        .regs_rs2_out       (regs_rs2_out),
        .regs_rd_out        (regs_rd_out),
        .regs_rd_write_out  (regs_rd_write_out),
        .regs_rd_value_out  (regs_rd_value_out),
        .regs_rs1_value_in  (regs_rs1_value_in),
        .regs_rs2_value_in  (regs_rs2_value_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: garbage at power-up, x0 hard-wired, old data on collision
    logic [31:0] mem [32];
    logic [31:0] rf_q1;
    logic [31:0] rf_q2;
    bit          rf_init;

    always @(posedge clk) begin
        if (!rf_init) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= (i == 0) ? 32'd0 : $urandom;
            end
            rf_q1   <= $urandom;
            rf_q2   <= $urandom;
            rf_init <= 1'b1;
        end else begin
            if (regs_rd_write_out && regs_rd_out != 5'd0) begin
                mem[regs_rd_out] <= regs_rd_value_out;
            end
            if (!regs_stall_out) begin
                rf_q1 <= mem[regs_rs1_out];
                rf_q2 <= mem[regs_rs2_out];
            end
        end
    end

    assign regs_rs1_value_in = rf_q1;
    assign regs_rs2_value_in = rf_q2;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        stall;
    } pexp_t;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          due;
    } dexp_t;

    pexp_t q_pipe[$];
    dexp_t q_dbg[$];

    int n_vec;
    int n_err;
    int cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pipeline view every modelled cycle, debug on each ack
    always @(negedge clk) begin : mon
        pexp_t e;
        dexp_t d;
        if (q_pipe.size() > 0) begin
            e = q_pipe.pop_front();
            chk("pipe_rs1_value", pipe_rs1_value_out, e.rs1);
            chk("pipe_rs2_value", pipe_rs2_value_out, e.rs2);
            chk("pipe_stall", {31'd0, pipe_stall_out}, {31'd0, e.stall});
            chk("clear_done", {31'd0, clear_done_out}, 32'd1);
        end
        if (dbg_ack_out === 1'b1) begin
            if (q_dbg.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dbg_ack: got unexpected ack, want none (cycle %0d)",
                         cyc);
            end else begin
                d = q_dbg.pop_front();
                chk("dbg_ack_cycle", 32'(cyc), 32'(d.due));
                if (d.rd) chk("dbg_rdata", dbg_rdata_out, d.data);
            end
        end else if (q_dbg.size() > 0 && q_dbg[0].due <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL dbg_ack: got no ack, want ack (cycle %0d)", cyc);
            void'(q_dbg.pop_front());
        end
    end

    // Architectural reference model
    logic [31:0] arch [32];
    logic [4:0]  m_a1;
    logic [4:0]  m_a2;
    int          m_st;
    bit          dbg_active;
    bit          dbg_wr;
    logic [4:0]  dbg_a;
    logic [31:0] dbg_wd;

    function automatic logic [31:0] val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : arch[a];
    endfunction

    task automatic dbg_start(input bit wr, input logic [4:0] a,
                             input logic [31:0] wd);
        dbg_active = 1'b1;
        dbg_wr     = wr;
        dbg_a      = a;
        dbg_wd     = wd;
    endtask

    // One cycle of stimulus; predicts effects and the next cycle's view
    task automatic step(input bit st, input logic [4:0] r1,
                        input logic [4:0] r2, input bit we,
                        input logic [4:0] rd, input logic [31:0] wv);
        pexp_t e;
        bit    pw;
        bit    grant;
        int    old;
        pipe_stall_in    = st;
        pipe_rs1_in      = r1;
        pipe_rs2_in      = r2;
        pipe_rd_write_in = we;
        pipe_rd_in       = rd;
        pipe_rd_value_in = wv;
        dbg_req_in       = dbg_active;
        dbg_write_in     = dbg_wr;
        dbg_addr_in      = dbg_a;
        dbg_wdata_in     = dbg_wd;
        pw    = we && (rd != 5'd0);
        grant = (m_st == 0) && dbg_active && dbg_wr && !pw;
        if (pw) arch[rd] = wv;
        if (grant) begin
            if (dbg_a != 5'd0) arch[dbg_a] = dbg_wd;
            q_dbg.push_back('{rd: 1'b0, data: 32'd0, due: cyc});
        end
        old = m_st;
        if (m_st == 0) begin
            if (!st) begin
                m_a1 = r1;
                m_a2 = r2;
            end
            if (dbg_active && !dbg_wr) m_st = 1;
        end else if (m_st == 1) begin
            q_dbg.push_back('{rd: 1'b1, data: val(dbg_a), due: cyc + 1});
            m_st = 2;
        end else begin
            m_st = 0;
            dbg_active = 1'b0;
        end
        if (grant) dbg_active = 1'b0;
        e.rs1   = (old == 1) ? val(dbg_a) : val(m_a1);
        e.rs2   = val(m_a2);
        e.stall = (m_st != 0);
        q_pipe.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset, check reset values and the clear sweep, then re-arm the model
    task automatic do_reset();
        pexp_t e;
        reset_n          = 1'b0;
        pipe_stall_in    = 1'b0;
        pipe_rd_write_in = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_pipe_stall", {31'd0, pipe_stall_out}, 32'd1);
            chk("rst_clear_done", {31'd0, clear_done_out}, 32'd0);
            chk("rst_dbg_ack", {31'd0, dbg_ack_out}, 32'd0);
            chk("rst_dbg_rdata", dbg_rdata_out, 32'd0);
            chk("rst_rd_write", {31'd0, regs_rd_write_out}, 32'd1);
            chk("rst_rd", {27'd0, regs_rd_out}, 32'd1);
            chk("rst_rd_value", regs_rd_value_out, 32'd0);
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            pipe_rd_write_in = 1'($urandom_range(0, 1));
            pipe_rd_in       = 5'($urandom);
            pipe_rd_value_in = $urandom;
            @(negedge clk);
            chk("clr_write", {31'd0, regs_rd_write_out}, 32'd1);
            chk("clr_rd", {27'd0, regs_rd_out}, 32'(i));
            chk("clr_value", regs_rd_value_out, 32'd0);
            chk("clr_stall", {31'd0, pipe_stall_out}, 32'd1);
            chk("clr_done", {31'd0, clear_done_out}, 32'd0);
            @(posedge clk);
            #1;
        end
        pipe_rd_write_in = 1'b0;
        for (int i = 0; i < 32; i++) arch[i] = 32'd0;
        m_a1 = 5'd0;
        m_a2 = 5'd0;
        m_st = 0;
        e.rs1   = 32'd0;
        e.rs2   = 32'd0;
        e.stall = 1'b0;
        q_pipe.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        reset_n          = 1'b0;
        pipe_stall_in    = 1'b0;
        pipe_rs1_in      = 5'd0;
        pipe_rs2_in      = 5'd0;
        pipe_rd_in       = 5'd0;
        pipe_rd_write_in = 1'b0;
        pipe_rd_value_in = 32'd0;
        dbg_req_in       = 1'b0;
        dbg_write_in     = 1'b0;
        dbg_addr_in      = 5'd0;
        dbg_wdata_in     = 32'd0;
        dbg_active       = 1'b0;
        dbg_wr           = 1'b0;
        dbg_a            = 5'd0;
        dbg_wd           = 32'd0;

        do_reset();

        // Read of x5 after clear
        step(0, 5, 5, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Bypass on issue, then while held
        step(0, 3, 4, 1, 3, 32'hDEADBEEF);
        step(1, 7, 7, 1, 3, 32'h12345678);
        step(1, 7, 7, 0, 0, 0);

        // x0 stays zero
        step(0, 0, 0, 1, 0, 32'hFFFFFFFF);
        step(0, 0, 0, 0, 0, 0);

        // Debug write blocked by three pipeline writes
        dbg_start(1, 7, 32'hA5A5A5A5);
        repeat (3) step(1, 0, 0, 1, 9, $urandom);
        step(1, 0, 0, 0, 0, 0);
        dbg_start(0, 7, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0);

        // Debug read while the pipeline holds x1/x2
        step(0, 0, 0, 1, 1, 32'h11);
        step(0, 0, 0, 1, 2, 32'h22);
        step(0, 1, 2, 0, 0, 0);
        dbg_start(0, 2, 0);
        repeat (5) step(1, 9, 9, 0, 0, 0);

        // Reset in the middle of a debug read
        step(0, 0, 0, 1, 5, 32'h55);
        dbg_start(0, 5, 0);
        step(0, 5, 5, 0, 0, 0);
        do_reset();
        repeat (4) step(1, 0, 0, 0, 0, 0);
        step(0, 5, 9, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!dbg_active && $urandom_range(0, 7) == 0) begin
                dbg_start(1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), $urandom);
            end
            step(1'($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)),
                 $urandom);
        end

        for (int n = 0; n < 20 && (dbg_active || m_st != 0); n++) begin
            step(1, 0, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("dbg_pending", 32'(q_dbg.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
